// File: rtl/vector_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU result sources, the arbiter and the vector register file.
// The slave modport is the arbiter's view; master is the environment driving it.
interface vector_wb_arbiter_if #(
   parameter int unsigned VLEN_BITS = 128,
   parameter int unsigned NUM_LANES = 4
);
   logic                             alu_wb_valid;
   logic                             alu_wb_ready;
   logic [4:0]                       alu_wb_vd;
   logic                             alu_wb_lmul;
   logic                             alu_wb_sew;
   logic                             alu_wb_red;
   logic [NUM_LANES*VLEN_BITS-1:0]   alu_wb_data;

   logic                             lsu_wb_valid;
   logic                             lsu_wb_ready;
   logic [4:0]                       lsu_wb_vd;
   logic                             lsu_wb_lmul;
   logic                             lsu_wb_sew;
   logic                             lsu_wb_red;
   logic [NUM_LANES*VLEN_BITS-1:0]   lsu_wb_data;

   logic                             rf_wr_stall;
   logic [NUM_LANES-1:0][4:0]        vsi_rf_waddr;
   logic [NUM_LANES-1:0][VLEN_BITS/8-1:0] vsi_rf_wstrb;
   logic [NUM_LANES-1:0][VLEN_BITS-1:0]   vsi_rf_wdata;
   logic                             wb_done;
   logic                             wb_done_src;
   logic [31:0]                      vd_busy;

   modport slave (
      input  alu_wb_valid, alu_wb_vd, alu_wb_lmul, alu_wb_sew, alu_wb_red, alu_wb_data,
      input  lsu_wb_valid, lsu_wb_vd, lsu_wb_lmul, lsu_wb_sew, lsu_wb_red, lsu_wb_data,
      input  rf_wr_stall,
      output alu_wb_ready, lsu_wb_ready,
      output vsi_rf_waddr, vsi_rf_wstrb, vsi_rf_wdata, wb_done, wb_done_src, vd_busy
   );

   modport master (
      output alu_wb_valid, alu_wb_vd, alu_wb_lmul, alu_wb_sew, alu_wb_red, alu_wb_data,
      output lsu_wb_valid, lsu_wb_vd, lsu_wb_lmul, lsu_wb_sew, lsu_wb_red, lsu_wb_data,
      output rf_wr_stall,
      input  alu_wb_ready, lsu_wb_ready,
      input  vsi_rf_waddr, vsi_rf_wstrb, vsi_rf_wdata, wb_done, wb_done_src, vd_busy
   );
endinterface

// File: rtl/vector_wb_arbiter.sv
// Round-robin arbiter sharing the 4-lane vector RF write port between ALU (0) and LSU (1),
// with a single stall-able output stage and a pending-destination busy scoreboard.
module vector_wb_arbiter #(
   parameter int unsigned VLEN_BITS = 128,
   parameter int unsigned NUM_LANES = 4
) (
   input logic                clk,
   input logic                rst_n,
   vector_wb_arbiter_if.slave wb
);
   localparam int unsigned StrbW = VLEN_BITS / 8;
   localparam int unsigned DataW = NUM_LANES * VLEN_BITS;

   typedef enum logic [1:0] {StIdle, StWrite, StHold} state_e;

   typedef struct packed {
      logic             src;
      logic [4:0]       vd;
      logic             lmul;
      logic             sew;
      logic             red;
      logic [DataW-1:0] data;
   } req_t;

   req_t        out_q, out_d;
   req_t        alu_req, lsu_req;
   logic        out_valid_q, out_valid_d;
   logic        rr_last_q, rr_last_d;
   logic [31:0] vd_busy_q, vd_busy_d;
   logic [31:0] set_mask, clr_mask;
   state_e      state;
   logic        accept;
   logic        grant_src;

   // Registers a request will write: a wrapping 4-register group, or just vd.
   function automatic logic [31:0] reg_mask(input logic [4:0] vd, input logic lmul,
                                            input logic red);
      logic [31:0] m;
      logic [4:0]  idx;
      m = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         idx = vd + 5'(k);
         if (k == 0 || (lmul && !red)) m[idx] = 1'b1;
      end
      return m;
   endfunction

   always_comb begin
      alu_req = '{src: 1'b0, vd: wb.alu_wb_vd, lmul: wb.alu_wb_lmul, sew: wb.alu_wb_sew,
                  red: wb.alu_wb_red, data: wb.alu_wb_data};
      lsu_req = '{src: 1'b1, vd: wb.lsu_wb_vd, lmul: wb.lsu_wb_lmul, sew: wb.lsu_wb_sew,
                  red: wb.lsu_wb_red, data: wb.lsu_wb_data};
   end

   always_comb begin
      if (!out_valid_q)        state = StIdle;
      else if (wb.rf_wr_stall) state = StHold;
      else                     state = StWrite;

      // On a tie the source that did not win last time is granted.
      grant_src = (wb.alu_wb_valid && wb.lsu_wb_valid) ? !rr_last_q : wb.lsu_wb_valid;
      accept    = (state != StHold) && (wb.alu_wb_valid || wb.lsu_wb_valid);

      wb.alu_wb_ready = accept && !grant_src;
      wb.lsu_wb_ready = accept && grant_src;

      out_valid_d = accept || (state == StHold);
      out_d       = accept ? (grant_src ? lsu_req : alu_req) : out_q;
      rr_last_d   = accept ? grant_src : rr_last_q;

      set_mask  = accept ? reg_mask(out_d.vd, out_d.lmul, out_d.red) : '0;
      clr_mask  = (state == StWrite) ? reg_mask(out_q.vd, out_q.lmul, out_q.red) : '0;
      vd_busy_d = (vd_busy_q & ~clr_mask) | set_mask;
   end

   always_comb begin
      wb.vsi_rf_waddr = '0;
      wb.vsi_rf_wstrb = '0;
      wb.vsi_rf_wdata = '0;
      wb.wb_done      = (state == StWrite);
      wb.wb_done_src  = (state == StWrite) && out_q.src;
      wb.vd_busy      = vd_busy_q;
      if (state == StWrite) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            if (out_q.red) begin
               if (k == 0) begin
                  wb.vsi_rf_waddr[k] = out_q.vd;
                  wb.vsi_rf_wstrb[k] = out_q.sew ? StrbW'(16'h000F) : StrbW'(16'h0001);
                  wb.vsi_rf_wdata[k] = out_q.data[VLEN_BITS-1:0];
               end
            end else if (out_q.lmul || k == 0) begin
               wb.vsi_rf_waddr[k] = out_q.vd + 5'(k);
               wb.vsi_rf_wstrb[k] = '1;
               wb.vsi_rf_wdata[k] = out_q.data[k*VLEN_BITS +: VLEN_BITS];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         rr_last_q   <= 1'b1;
         vd_busy_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         rr_last_q   <= rr_last_d;
         vd_busy_q   <= vd_busy_d;
      end
   end
endmodule

// File: doc/vector_wb_arbiter.md
Name: vector_wb_arbiter

Overview:
- Shares the single 4-lane vector register-file write port (vsi_rf_waddr/wstrb/wdata) between two writeback sources: the vector ALU (source 0) and the vector load unit (source 1).
- Uses valid/ready handshakes with round-robin arbitration.
- Holds one registered output stage that stalls while the register file is busy.
- Tracks pending destination registers in a busy scoreboard for the issue stage.

Parameters:
VLEN_BITS, 128, width of one vector register / one write lane
NUM_LANES, 4, number of write lanes; only 4 is supported

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
alu_wb_valid  in  1  ALU writeback request
alu_wb_ready  out  1  ALU request accepted this cycle
alu_wb_vd  in  5  destination register index
alu_wb_lmul  in  1  1 = 4-register group, 0 = single register
alu_wb_sew  in  1  1 = 32-bit element, 0 = 8-bit element
alu_wb_red  in  1  reduction result; only element 0 is written
alu_wb_data  in  512  result; lane k = bits [128k+127:128k]
lsu_wb_valid, lsu_wb_ready, lsu_wb_vd, lsu_wb_lmul, lsu_wb_sew, lsu_wb_red, lsu_wb_data  same widths/meaning for the load unit
rf_wr_stall  in  1  register-file port unavailable this cycle
vsi_rf_waddr  out  4x5  per-lane write address
vsi_rf_wstrb  out  4x16  per-lane byte strobes
vsi_rf_wdata  out  4x128  per-lane write data
wb_done  out  1  pulse: a write was performed this cycle
wb_done_src  out  1  source of that write (0 = ALU, 1 = LSU)
vd_busy  out  32  bit r set = a write to vr[r] is pending

Behaviour:
Reset (sync, rst_n low at a clk edge):
- out_valid=0, state IDLE.
- vd_busy=0, wb_done=0, wb_done_src=0.
- rr_last=1, so the ALU wins the first tie.
- All vsi_rf_* outputs are 0. Any pending write is dropped and produces no strobe, including a reset asserted mid-stall.

State machine (derived from out_valid and rf_wr_stall):
- IDLE: no pending write.
- WRITE: pending write and rf_wr_stall=0. The write is presented this cycle.
- HOLD: pending write and rf_wr_stall=1. Strobes forced to 0; addresses and data may hold their values.
- Transitions: IDLE -> WRITE or HOLD on accept. WRITE -> IDLE if no new accept, WRITE -> WRITE/HOLD on back-to-back accept. HOLD -> WRITE when stall drops.

Accept and arbitration:
- can_accept = !out_valid || !rf_wr_stall.
- If only one source is valid, it is granted. If both are valid, the source != rr_last is granted.
- ready = can_accept && granted, combinational from valid and state. Neither ready is asserted while in HOLD.
- rr_last updates to the granted source on every accept.

Pipeline and throughput:
- The request accepted at edge N is registered and drives vsi_rf_* in cycle N+1 (1-cycle latency).
- Throughput is one writeback per cycle when there is no stall.

Lane mapping (applies only when state is WRITE; every unused lane has addr=0, strb=0, data=0):
- red=1: lane0 addr=vd, strb=16'h000F if sew else 16'h0001, data=data[127:0]. lmul is ignored.
- red=0, lmul=1: lane k addr=(vd+k) mod 32 (5-bit wrap, vd=30 gives 30,31,0,1), strb=16'hFFFF, data=slice k.
- red=0, lmul=0: lane0 only, addr=vd, strb=16'hFFFF, data=data[127:0].

wb_done:
- Asserted combinationally in WRITE, with wb_done_src = source of the registered request. 0 otherwise.

vd_busy scoreboard:
- On accept, set the bit(s) the request will write: all 4 group registers (with wrap) for lmul=1 non-red, else bit vd.
- In WRITE, clear the bit(s) being written.
- Same bit set and cleared in the same cycle: set wins.
- A new request hitting an already-busy vd is still accepted. Ordering is preserved by the single output stage.

Data capture and held inputs:
- Data is captured at accept. A requester may change its inputs after its ready/valid handshake completes.
- While valid and not ready, the requester must hold its inputs stable.

Test Plan:
- Reset then ALU valid, vd=4, lmul=1, red=0, data lanes A,B,C,D -> alu_wb_ready=1 same cycle. Next cycle: waddr={7,6,5,4} (lane3..0), all strobes FFFF, wdata lanes=A..D, wb_done=1, wb_done_src=0. vd_busy[7:4] is 1 for exactly one cycle.
- Both valid every cycle for 4 cycles, no stall -> grants go ALU, LSU, ALU, LSU. Writes appear one cycle after each grant, with no bubbles.
- LSU accepted, then rf_wr_stall=1 for 3 cycles -> strobes 0, both readies 0, wb_done 0 throughout. Write appears on the first cycle stall=0. vd_busy bit stays set until that cycle.
- Reduction cases: red=1, sew=1, vd=9 -> lane0 strb=000F, addr=9, lanes 1-3 zero. red=1, sew=0 -> lane0 strb=0001.
- Wrap case: lmul=1, vd=30 -> waddr lanes 0..3 = 30,31,0,1. vd_busy bits 30,31,0,1 set.
- rst_n low for one edge while in HOLD -> next cycle all strobes 0, vd_busy=0. The dropped write never appears after the stall clears.
